apb_master_ctrl: RTL and testbench
==================================

// Module: apb_master_ctrl
// PURPOSE
//   APB3-style initiator (no PSLVERR, no PPROT/PSTRB) that turns a simple valid/ready command
//   into a full SETUP/ACCESS transfer to an APB target such as the logic_op register block.
//   Returns read data or timeout status as a one-cycle response pulse.
//   Sits between a host/test sequencer and the APB bus; single outstanding transfer.
// PARAMETERS
//   ADDR_W        32   width of cmd_addr / paddr
//   DATA_W        32   width of cmd_wdata / pwdata / prdata / rsp_rdata
//   TIMEOUT_CYC   16   max ACCESS cycles with pready=0 before abort; 0 disables timeout
// PORTS
//   pclk         in   1       clock; all logic on rising edge
//   presetn      in   1       asynchronous active-low reset
//   cmd_valid    in   1       command request
//   cmd_ready    out  1       block can accept a command (high only in IDLE)
//   cmd_write    in   1       1=write, 0=read
//   cmd_addr     in   ADDR_W  target address
//   cmd_wdata    in   DATA_W  write data (ignored for reads)
//   rsp_valid    out  1       one-cycle pulse: transfer finished
//   rsp_rdata    out  DATA_W  read data, valid with rsp_valid (0 for writes and timeouts)
//   rsp_timeout  out  1       valid with rsp_valid: transfer aborted by timeout
//   psel         out  1       APB select
//   penable      out  1       APB enable
//   pwrite       out  1       APB direction
//   paddr        out  ADDR_W  APB address
//   pwdata       out  DATA_W  APB write data
//   prdata       in   DATA_W  APB read data
//   pready       in   1       APB ready
// BEHAVIOUR
//   Reset: state=IDLE; psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata,
//     rsp_timeout, timeout counter all 0. Reset mid-transfer aborts silently: no rsp_valid.
//   All APB and rsp outputs are registered; cmd_ready is decoded directly from state==IDLE.
//   FSM: IDLE -> SETUP -> ACCESS -> IDLE.
//   IDLE: cmd_ready=1, psel=0, penable=0. On cmd_valid&cmd_ready: latch write/addr/wdata
//     into pwrite/paddr/pwdata, set psel=1, go SETUP. cmd_valid with cmd_ready=0 is ignored;
//     the requester holds the command.
//   SETUP (exactly 1 cycle): psel=1, penable=0; next edge sets penable=1, goes ACCESS.
//   ACCESS: psel=1, penable=1, paddr/pwrite/pwdata stable.
//     pready=1 -> psel=0, penable=0, rsp_valid=1, rsp_timeout=0,
//       rsp_rdata=prdata if read, else 0; go IDLE.
//     pready=0 -> wait-state counter +1. When TIMEOUT_CYC!=0 and counter reaches
//       TIMEOUT_CYC, abort: psel=0, penable=0, rsp_valid=1, rsp_timeout=1, rsp_rdata=0;
//       go IDLE.
//     Counter clears on entry to SETUP. It saturates and never wraps; width is
//       $clog2(TIMEOUT_CYC+1), minimum 1.
//   Latency: command accepted at edge N -> SETUP in cycle N+1 -> ACCESS in cycle N+2.
//     With zero wait states, rsp_valid is high in cycle N+3, which is also an IDLE cycle.
//     A new command may be accepted in that cycle, so back-to-back transfers repeat every 3 cycles.
//   rsp_valid is high for exactly 1 cycle with no backpressure. rsp_rdata/rsp_timeout hold
//     their value until the next response.
//   paddr/pwdata/pwrite keep their last value while idle; they change only at command accept.
//   pready/prdata are sampled only in ACCESS; a pready seen in IDLE or SETUP is ignored.
// STRUCTURE
//   Shared package apb_pkg: state encoding localparams (IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2),
//     default ADDR_W/DATA_W, and the logic_op register address constants used by the benches.
//   One sub-module: apb_wait_timer, a saturating counter with clear/inc inputs and a
//     parameterised terminal-count flag. Everything else is flat in apb_master_ctrl.
// TESTING
//   1 Write: cmd write addr=0x0 wdata=0x2, target pready=1 -> SETUP 1 cycle then ACCESS 1 cycle
//     with pwrite=1, paddr=0x0, pwdata=0x2; rsp_valid 3 cycles after accept, rsp_timeout=0, rsp_rdata=0.
//   2 Read: read addr=0x0 after test 1, target returns 0x2 -> rsp_rdata=0x2, rsp_timeout=0;
//     a logic_op target then selects XNOR.
//   3 Wait states: target holds pready=0 for 3 ACCESS cycles -> penable high 4 cycles,
//     paddr stable throughout, single rsp_valid, rsp_timeout=0.
//   4 Timeout: TIMEOUT_CYC=4, pready tied 0 -> abort after 4 ACCESS cycles: psel=0,
//     rsp_valid=1, rsp_timeout=1, rsp_rdata=0; next command accepted normally.
//   5 Back-to-back: cmd_valid held for 3 commands (W 0x0=0x1, R 0x0, W 0x0=0x3), zero wait
//     states -> accepts every 3 cycles, psel low exactly 1 cycle between transfers, R returns 0x1.
//   6 Reset mid-ACCESS: presetn low while pready=0 -> psel/penable/rsp_valid 0 immediately
//     (async), no response pulse after release, cmd_ready=1 on the first cycle out of reset.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding, default bus widths and
// the logic_op register map used by the benches.
package apb_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    // logic_op target register map; writing 2 to the select register picks XNOR
    localparam logic [31:0] LOGIC_OP_SEL_ADDR = 32'h0000_0000;
    localparam logic [31:0] LOGIC_OP_A_ADDR   = 32'h0000_0004;
    localparam logic [31:0] LOGIC_OP_B_ADDR   = 32'h0000_0008;
    localparam logic [31:0] LOGIC_OP_RES_ADDR = 32'h0000_000C;
    localparam logic [31:0] LOGIC_OP_XNOR     = 32'h0000_0002;

endpackage

// File: rtl/apb_wait_timer.sv
// Saturating wait-state counter; expire flags the increment that makes
// the count reach TIMEOUT_CYC (never asserted when TIMEOUT_CYC is 0).
module apb_wait_timer #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic inc,
    output logic expire
);

    localparam int CW = (TIMEOUT_CYC == 0) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] ONE  = CW'(1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] count;

    assign expire = (TIMEOUT_CYC != 0) && inc && (count == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/apb_master_ctrl.sv
// APB3 initiator: converts a valid/ready command into one SETUP/ACCESS
// transfer and returns a single-cycle response (read data or timeout).
module apb_master_ctrl
    import apb_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_timeout,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready
);

    apb_state_e state;
    logic       accept;
    logic       wait_inc;
    logic       expire;

    assign cmd_ready = (state == IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign wait_inc  = (state == ACCESS) && !pready;

    apb_wait_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wait_timer (
        .clk    (pclk),
        .rst_n  (presetn),
        .clear  (accept),
        .inc    (wait_inc),
        .expire (expire)
    );

    // rsp_valid defaults low so a response is only ever a single-cycle pulse
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state       <= IDLE;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_timeout <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        pwrite <= cmd_write;
                        paddr  <= cmd_addr;
                        pwdata <= cmd_wdata;
                        psel   <= 1'b1;
                        state  <= SETUP;
                    end
                end
                SETUP: begin
                    penable <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (pready) begin
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_timeout <= 1'b0;
                        rsp_rdata   <= pwrite ? '0 : prdata;
                        state       <= IDLE;
                    end else if (expire) begin
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_rdata   <= '0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    psel    <= 1'b0;
                    penable <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Directed bench for apb_master_ctrl: the bench plays the APB target by hand
// and checks every output against hand-computed values.
module tb_apb_master_ctrl;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              pclk;
    logic              presetn;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_timeout;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;

    int errors = 0;
    int checks = 0;

    apb_master_ctrl #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .TIMEOUT_CYC (4)
    ) dut (
        .pclk        (pclk),
        .presetn     (presetn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_timeout (rsp_timeout),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .paddr       (paddr),
        .pwdata      (pwdata),
        .prdata      (prdata),
        .pready      (pready)
    );

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic write,
                                 input logic [ADDR_W-1:0] addr,
                                 input logic [DATA_W-1:0] wdata);
        cmd_valid = valid;
        cmd_write = write;
        cmd_addr  = addr;
        cmd_wdata = wdata;
    endtask

    task automatic checkOutput(input string tag, input logic [DATA_W-1:0] observed,
                               input logic [DATA_W-1:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkBus(input string tag, input logic exp_psel, input logic exp_penable,
                            input logic exp_rsp_valid, input logic exp_cmd_ready);
        checkOutput({tag, ".psel"},      32'(psel),      32'(exp_psel));
        checkOutput({tag, ".penable"},   32'(penable),   32'(exp_penable));
        checkOutput({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(exp_rsp_valid));
        checkOutput({tag, ".cmd_ready"}, 32'(cmd_ready), 32'(exp_cmd_ready));
    endtask

    initial begin
        presetn = 1'b0;
        pready  = 1'b0;
        prdata  = '0;
        applyStimulus(1'b0, 1'b0, '0, '0);
        #2;
        $display("[TB] reset state");
        checkBus("rst", 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("rst.paddr", paddr, 32'h0);
        checkOutput("rst.rsp_rdata", rsp_rdata, 32'h0);
        checkOutput("rst.rsp_timeout", 32'(rsp_timeout), 32'h0);
        step();
        step();
        presetn = 1'b1;
        step();

        // Write; pready held high during IDLE/SETUP must be ignored
        $display("[TB] test 1: write 0x0=0x2");
        pready = 1'b1;
        prdata = 32'hDEAD_BEEF;
        applyStimulus(1'b1, 1'b1, apb_pkg::LOGIC_OP_SEL_ADDR, apb_pkg::LOGIC_OP_XNOR);
        step();
        applyStimulus(1'b0, 1'b0, 32'h0000_0FF0, 32'h0000_00AA);
        checkBus("t1.setup", 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("t1.pwrite", 32'(pwrite), 32'h1);
        checkOutput("t1.paddr", paddr, 32'h0);
        checkOutput("t1.pwdata", pwdata, 32'h2);
        step();
        checkBus("t1.access", 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        checkBus("t1.rsp", 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("t1.rsp_timeout", 32'(rsp_timeout), 32'h0);
        checkOutput("t1.rsp_rdata", rsp_rdata, 32'h0);
        checkOutput("t1.paddr_hold", paddr, 32'h0);
        step();
        checkBus("t1.after", 1'b0, 1'b0, 1'b0, 1'b1);

        $display("[TB] test 2: read 0x0");
        prdata = 32'h0000_0002;
        applyStimulus(1'b1, 1'b0, apb_pkg::LOGIC_OP_SEL_ADDR, 32'h0);
        step();
        applyStimulus(1'b0, 1'b0, '0, '0);
        checkOutput("t2.pwrite", 32'(pwrite), 32'h0);
        step();
        checkBus("t2.access", 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        checkBus("t2.rsp", 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("t2.rsp_rdata", rsp_rdata, 32'h2);
        checkOutput("t2.rsp_timeout", 32'(rsp_timeout), 32'h0);
        step();

        // Three wait states, ready on the fourth ACCESS cycle (one short of timeout)
        $display("[TB] test 3: wait states");
        pready = 1'b0;
        prdata = 32'h0000_0005;
        applyStimulus(1'b1, 1'b0, apb_pkg::LOGIC_OP_B_ADDR, 32'h0);
        step();
        applyStimulus(1'b0, 1'b0, '0, '0);
        step();
        for (int i = 0; i < 4; i++) begin
            pready = (i == 3);
            checkBus($sformatf("t3.acc%0d", i), 1'b1, 1'b1, 1'b0, 1'b0);
            checkOutput($sformatf("t3.paddr%0d", i), paddr, 32'h8);
            step();
        end
        checkBus("t3.rsp", 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("t3.rsp_rdata", rsp_rdata, 32'h5);
        checkOutput("t3.rsp_timeout", 32'(rsp_timeout), 32'h0);
        step();
        checkOutput("t3.single_pulse", 32'(rsp_valid), 32'h0);

        $display("[TB] test 4: timeout");
        pready = 1'b0;
        applyStimulus(1'b1, 1'b1, apb_pkg::LOGIC_OP_A_ADDR, 32'h7);
        step();
        applyStimulus(1'b0, 1'b0, '0, '0);
        step();
        for (int i = 0; i < 4; i++) begin
            checkBus($sformatf("t4.acc%0d", i), 1'b1, 1'b1, 1'b0, 1'b0);
            step();
        end
        checkBus("t4.abort", 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("t4.rsp_timeout", 32'(rsp_timeout), 32'h1);
        checkOutput("t4.rsp_rdata", rsp_rdata, 32'h0);
        pready = 1'b1;
        prdata = 32'h0000_0002;
        applyStimulus(1'b1, 1'b0, apb_pkg::LOGIC_OP_SEL_ADDR, 32'h0);
        step();
        applyStimulus(1'b0, 1'b0, '0, '0);
        checkBus("t4.next_setup", 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("t4.timeout_hold", 32'(rsp_timeout), 32'h1);
        step();
        step();
        checkBus("t4.next_rsp", 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("t4.next_rdata", rsp_rdata, 32'h2);
        checkOutput("t4.next_timeout", 32'(rsp_timeout), 32'h0);
        step();

        // Requester keeps cmd_valid high and swaps to the next command after each accept
        $display("[TB] test 5: back-to-back");
        pready = 1'b1;
        prdata = 32'h0000_0001;
        applyStimulus(1'b1, 1'b1, 32'h0, 32'h1);
        step();
        applyStimulus(1'b1, 1'b0, 32'h0, 32'h0);
        checkBus("t5.w1_setup", 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("t5.w1_pwdata", pwdata, 32'h1);
        step();
        checkOutput("t5.w1_pwrite_stable", 32'(pwrite), 32'h1);
        step();
        checkBus("t5.w1_rsp", 1'b0, 1'b0, 1'b1, 1'b1);
        step();
        applyStimulus(1'b1, 1'b1, 32'h0, 32'h3);
        checkBus("t5.r_setup", 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("t5.r_pwrite", 32'(pwrite), 32'h0);
        step();
        step();
        checkBus("t5.r_rsp", 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("t5.r_rdata", rsp_rdata, 32'h1);
        step();
        applyStimulus(1'b0, 1'b0, '0, '0);
        checkBus("t5.w3_setup", 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("t5.w3_pwdata", pwdata, 32'h3);
        step();
        step();
        checkBus("t5.w3_rsp", 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("t5.w3_rdata", rsp_rdata, 32'h0);
        step();
        checkBus("t5.idle", 1'b0, 1'b0, 1'b0, 1'b1);

        $display("[TB] test 6: reset mid-ACCESS");
        pready = 1'b0;
        applyStimulus(1'b1, 1'b0, apb_pkg::LOGIC_OP_RES_ADDR, 32'h0);
        step();
        applyStimulus(1'b0, 1'b0, '0, '0);
        step();
        step();
        checkBus("t6.access", 1'b1, 1'b1, 1'b0, 1'b0);
        #2;
        presetn = 1'b0;
        #1;
        checkBus("t6.async", 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("t6.paddr", paddr, 32'h0);
        step();
        presetn = 1'b1;
        pready  = 1'b1;
        checkOutput("t6.cmd_ready", 32'(cmd_ready), 32'h1);
        for (int i = 0; i < 4; i++) begin
            step();
            checkBus($sformatf("t6.post%0d", i), 1'b0, 1'b0, 1'b0, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
